// File: rtl/async_fifo_rd_pkg.sv
// rtl/async_fifo_rd_pkg.sv - shared types and constants for the async FIFO read-side stream
package async_fifo_rd_pkg;

    localparam int BUF_DEPTH_MAX = 4;
    localparam int STAT_W        = 32;

    // Holds 0..BUF_DEPTH_MAX buffered words.
    typedef logic [2:0] occ_t;

endpackage

// File: rtl/rd_out_buf.sv
// rtl/rd_out_buf.sv - circular output buffer holding words captured from the FIFO read port
module rd_out_buf
    import async_fifo_rd_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic              deq,
    input  logic [DWIDTH-1:0] data_in,
    output occ_t              occ,
    output logic [DWIDTH-1:0] data_out
);

    logic [DWIDTH-1:0] mem [BUF_DEPTH_MAX];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;

    // Pointers wrap at BUF_DEPTH, which need not be a power of two.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Storage, pointers and occupancy; entries clear on reset so data_out reads 0 until data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH_MAX; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            occ <= occ + occ_t'(enq) - occ_t'(deq);
        end
    end

    assign data_out = mem[rd_ptr];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// rtl/async_fifo_rd_stream.sv - FIFO read port to valid/ready stream adapter; FIFO_RD_STATS_EN adds word/stall counters
module async_fifo_rd_stream
    import async_fifo_rd_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic              rclk,
    input  logic              reset_L,
    output logic              pop,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_word_cnt,
    output logic [STAT_W-1:0] rd_stall_cnt
`endif
);

    logic       inflight;
    logic       deq;
    occ_t       occ;
    logic [3:0] committed;

    assign deq       = out_valid && out_ready;
    assign out_valid = (occ != '0);

    // Words already owned by this block (buffered plus in flight), net of the word leaving now.
    assign committed = {1'b0, occ} + {3'b0, inflight} - {3'b0, deq};

    // Gated by reset so a held-off block never requests data it would then discard.
    assign pop = reset_L && !empty && (committed < 4'(BUF_DEPTH));

    // The FIFO returns data one cycle after the pop; remember that a word is on its way.
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop;
        end
    end

    rd_out_buf #(
        .DWIDTH    (DWIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (rclk),
        .rst_n    (reset_L),
        .enq      (inflight),
        .deq      (deq),
        .data_in  (rdata),
        .occ      (occ),
        .data_out (out_data)
    );

    occ_full_chk: assert property (@(posedge rclk) disable iff (!reset_L)
        ({1'b0, occ} + {3'b0, inflight}) <= 4'(BUF_DEPTH));

`ifdef FIFO_RD_STATS_EN
    // Delivered-word and sink-stall counters; free-running, wrap at 2^32.
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            rd_word_cnt  <= '0;
            rd_stall_cnt <= '0;
        end else begin
            if (deq) begin
                rd_word_cnt <= rd_word_cnt + STAT_W'(1);
            end
            if (out_valid && !out_ready) begin
                rd_stall_cnt <= rd_stall_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule
